shift_pipe: RTL and testbench

Two-stage pipelined 64-bit shift/rotate execution unit for the RV64 integer pipeline. It accepts one operation per cycle over a valid/ready handshake and returns results in order over a second valid/ready handshake. The block covers both shift directions, arithmetic fill, 32-bit word variants (SLLW/SRLW/SRAW) and optional rotates. Right shifts and right rotates are performed by bit-reversing the operand around a left-shifting core.

---
 rtl/shift_pipe_pkg.sv | 70 +++++++
 rtl/shift_pipe_bit_reverse.sv | 13 +
 rtl/shift_pipe.sv | 124 ++++++++++++
 tb/tb_shift_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pipe_pkg.sv
// Shared encodings and datapath helpers for the shift/rotate unit.
// Build option: define ROTATE_EN to implement ROL/ROR; otherwise they are reserved.
package shift_pipe_pkg;

  localparam int SHIFT_W = 64;
  localparam int SHAMT_W = 6;
  localparam int TAG_W   = 5;

`ifdef ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    SHIFT_OP_SLL = 3'b000,
    SHIFT_OP_SRL = 3'b001,
    SHIFT_OP_SRA = 3'b010,
    SHIFT_OP_ROL = 3'b011,
    SHIFT_OP_ROR = 3'b100
  } shift_op_e;

  // Intermediate held between the fine and coarse shift stages.
  typedef struct packed {
    logic [SHIFT_W-1:0] mid;
    logic [2:0]         amt_hi;
    logic [2:0]         op;
    logic               word;
    logic               fill;
    logic [TAG_W-1:0]   tag;
  } s1_t;

  function automatic logic is_right(input logic [2:0] op);
    return (op == SHIFT_OP_SRL) || (op == SHIFT_OP_SRA) || (op == SHIFT_OP_ROR);
  endfunction

  function automatic logic is_reserved(input logic [2:0] op);
    return (op > SHIFT_OP_ROR) ||
           (!ROT_EN && ((op == SHIFT_OP_ROL) || (op == SHIFT_OP_ROR)));
  endfunction

  // Left shift that feeds the fill bit into vacated low positions.
  function automatic logic [SHIFT_W-1:0] shl_fill(input logic [SHIFT_W-1:0] x,
                                                   input logic [5:0] n,
                                                   input logic fill);
    logic [SHIFT_W-1:0] mask;
    mask = ~({SHIFT_W{1'b1}} << n);
    return (x << n) | (fill ? mask : '0);
  endfunction

`ifdef ROTATE_EN
  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] f;
    f = {x, x} << n;
    return f[63:32];
  endfunction

  // Word rotates spin each half independently: only the half holding the
  // (possibly reversed) operand matters, the other half is all zero.
  function automatic logic [SHIFT_W-1:0] rot_core(input logic [SHIFT_W-1:0] x,
                                                   input logic [5:0] n,
                                                   input logic word);
    logic [2*SHIFT_W-1:0] f;
    f = {x, x} << n;
    if (word) return {rol32(x[63:32], n[4:0]), rol32(x[31:0], n[4:0])};
    return f[2*SHIFT_W-1:SHIFT_W];
  endfunction
`endif

endpackage

// File: rtl/shift_pipe_bit_reverse.sv
// Combinational 64-bit bit reversal used around the left-shift core.
module bit_reverse64
  import shift_pipe_pkg::*;
(
  input  logic [SHIFT_W-1:0] d_i,
  output logic [SHIFT_W-1:0] q_o
);

  for (genvar i = 0; i < SHIFT_W; i++) begin : g_rev
    assign q_o[i] = d_i[SHIFT_W-1-i];
  end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage RV64 shift/rotate unit: S1 fine shift (0-7), S2 coarse shift (x8).
// Build option: ROTATE_EN adds the rotate funnel for ROL/ROR and their W forms.
module shift_pipe
  import shift_pipe_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SHIFT_W-1:0] req_data,
  input  logic [SHAMT_W-1:0] req_shamt,
  input  logic [2:0]         req_op,
  input  logic               req_word,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [SHIFT_W-1:0] resp_data,
  output logic [TAG_W-1:0]   resp_tag
);

  logic               s1_valid_q, s1_valid_d;
  s1_t                s1_q, s1_d;
  logic               resp_valid_q, resp_valid_d;
  logic [SHIFT_W-1:0] resp_data_q, resp_data_d;
  logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;
  logic               s2_load, accept;

  assign s2_load   = !resp_valid_q || resp_ready;
  assign req_ready = !s1_valid_q || s2_load;
  assign accept    = req_valid && req_ready && !flush;

  // S1: effective operand, optional reversal, fine shift.
  logic [5:0]         amt;
  logic               fill;
  logic [SHIFT_W-1:0] eff, rev_in, opnd, fine;

  always_comb begin
    amt  = req_word ? {1'b0, req_shamt[4:0]} : req_shamt;
    fill = (req_op == SHIFT_OP_SRA) && (req_word ? req_data[31] : req_data[63]);
    eff  = req_word ? {{32{fill}}, req_data[31:0]} : req_data;
  end

  bit_reverse64 u_rev_in (.d_i(eff), .q_o(rev_in));

  assign opnd = is_right(req_op) ? rev_in : eff;

`ifdef ROTATE_EN
  assign fine = (req_op == SHIFT_OP_ROL || req_op == SHIFT_OP_ROR)
              ? rot_core(opnd, {3'b000, amt[2:0]}, req_word)
              : shl_fill(opnd, {3'b000, amt[2:0]}, fill);
`else
  assign fine = shl_fill(opnd, {3'b000, amt[2:0]}, fill);
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_d = '{mid: fine, amt_hi: amt[5:3], op: req_op, word: req_word,
               fill: fill, tag: req_tag};
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2: coarse shift, un-reverse, word sign-extension.
  logic [SHIFT_W-1:0] coarse, rev_out, res;

`ifdef ROTATE_EN
  assign coarse = (s1_q.op == SHIFT_OP_ROL || s1_q.op == SHIFT_OP_ROR)
                ? rot_core(s1_q.mid, {s1_q.amt_hi, 3'b000}, s1_q.word)
                : shl_fill(s1_q.mid, {s1_q.amt_hi, 3'b000}, s1_q.fill);
`else
  assign coarse = shl_fill(s1_q.mid, {s1_q.amt_hi, 3'b000}, s1_q.fill);
`endif

  bit_reverse64 u_rev_out (.d_i(coarse), .q_o(rev_out));

  always_comb begin
    res = is_right(s1_q.op) ? rev_out : coarse;
    if (s1_q.word) res = {{32{res[31]}}, res[31:0]};
    if (is_reserved(s1_q.op)) res = '0;
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    if (flush) begin
      resp_valid_d = 1'b0;
    end else if (s2_load) begin
      resp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        resp_data_d = res;
        resp_tag_d  = s1_q.tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_q         <= s1_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: driver pushes expected results, monitor pops on handshake.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, req_valid, req_ready, req_word, resp_valid, resp_ready;
  logic [63:0] req_data, resp_data;
  logic [5:0]  req_shamt;
  logic [2:0]  req_op;
  logic [4:0]  req_tag, resp_tag;

  shift_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_shamt(req_shamt), .req_op(req_op), .req_word(req_word), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic [4:0] tag; } exp_t;
  exp_t sb[$];
  int   n_vec = 0, n_bad = 0;
  int   rr_mode = 0, cyc = 0;
  bit   acc_now = 1'b0;

`ifdef ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

  // Reference: plain RISC-V semantics, rotates by repeated single-bit rotation.
  function automatic logic [63:0] model(input logic [63:0] d, input logic [5:0] sh,
                                        input logic [2:0] op, input bit w);
    logic [31:0]        lw, t32;
    logic signed [31:0] s32;
    logic signed [63:0] s64;
    logic [63:0]        t64;
    int                 n;
    lw = d[31:0];
    n  = w ? int'(sh[4:0]) : int'(sh);
    case (op)
      3'd0: begin t32 = lw << n; t64 = d << n; return w ? sext32(t32) : t64; end
      3'd1: begin t32 = lw >> n; t64 = d >> n; return w ? sext32(t32) : t64; end
      3'd2: begin
        s32 = lw; s64 = d;
        s32 = s32 >>> n; s64 = s64 >>> n;
        return w ? sext32(s32) : s64;
      end
      3'd3, 3'd4: begin
        if (!ROT) return 64'h0;
        t32 = lw; t64 = d;
        for (int i = 0; i < n; i++) begin
          if (op == 3'd3) begin t32 = {t32[30:0], t32[31]}; t64 = {t64[62:0], t64[63]}; end
          else            begin t32 = {t32[0], t32[31:1]};  t64 = {t64[0], t64[63:1]};  end
        end
        return w ? sext32(t32) : t64;
      end
      default: return 64'h0;
    endcase
  endfunction

  // One clock: drive at posedge+1, decide acceptance mid-cycle.
  task automatic step(input bit v, input logic [63:0] d, input logic [5:0] sh,
                      input logic [2:0] op, input bit w, input logic [4:0] tag,
                      input logic [63:0] e, input bit fl, output bit acc);
    @(posedge clk); #1;
    req_valid = v; req_data = d; req_shamt = sh; req_op = op; req_word = w;
    req_tag = tag; flush = fl;
    case (rr_mode)
      0:       resp_ready = 1'b1;
      1:       resp_ready = (cyc % 3 == 0);
      2:       resp_ready = 1'($urandom_range(0, 1));
      default: resp_ready = 1'b0;
    endcase
    cyc++;
    @(negedge clk);
    if (fl) begin
      sb.delete();
      acc = 1'b0;
    end else begin
      acc = v && req_ready;
      if (acc) sb.push_back('{data: e, tag: tag});
    end
    acc_now = acc;
  endtask

  task automatic idle();
    bit a;
    step(1'b0, 64'h0, 6'h0, 3'h0, 1'b0, 5'h0, 64'h0, 1'b0, a);
  endtask

  task automatic issue(input logic [63:0] d, input logic [5:0] sh, input logic [2:0] op,
                       input bit w, input logic [4:0] tag, input logic [63:0] e);
    bit acc = 1'b0;
    int k = 0;
    while (!acc && k < 20) begin
      step(1'b1, d, sh, op, w, tag, e, 1'b0, acc);
      k++;
    end
    if (!acc) chk("accept_timeout", 64'h0, 64'h1);
  endtask

  task automatic issue_rand(input logic [4:0] tag);
    logic [63:0] d;
    logic [5:0]  sh;
    logic [2:0]  op;
    bit          w;
    d  = {$urandom, $urandom};
    op = 3'($urandom_range(0, 7));
    w  = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 4))
      0: sh = 6'd0;  1: sh = 6'd63;  2: sh = 6'd31;  3: sh = 6'd32;
      default: sh = 6'($urandom);
    endcase
    issue(d, sh, op, w, tag, model(d, sh, op, w));
  endtask

  task automatic drain();
    int k = 0;
    rr_mode = 0;
    while (sb.size() > 0 && k < 60) begin idle(); k++; end
    if (sb.size() > 0) chk("drain_timeout", 64'(sb.size()), 64'h0);
  endtask

  // Monitor: mid-cycle, pop on handshake and check req_ready against occupancy.
  initial begin
    int  occ;
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst_n && !flush) begin
        occ = sb.size() - int'(acc_now);
        chk("req_ready", 64'(req_ready), 64'(!(occ == 2 && !resp_ready)));
        if (resp_valid && resp_ready) begin
          if (occ <= 0) begin
            chk("unexpected_resp", {59'h0, resp_tag}, 64'h0);
          end else begin
            e = sb.pop_front();
            chk("resp_data", resp_data, e.data);
            chk("resp_tag", 64'(resp_tag), 64'(e.tag));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_data = '0; req_shamt = '0;
    req_op = '0; req_word = 1'b0; req_tag = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #2;
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_resp_data", resp_data, 64'h0);
    chk("rst_resp_tag", 64'(resp_tag), 64'h0);

    // Directed corner cases with hand-computed results.
    rr_mode = 0;
    issue(64'h8000_0000_0000_0000, 6'd63, 3'd2, 1'b0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(64'h8000_0000_0000_0000, 6'd63, 3'd1, 1'b0, 5'd2, 64'h1);
    issue(64'h0000_0000_4000_0001, 6'd1,  3'd0, 1'b1, 5'd3, 64'hFFFF_FFFF_8000_0002);
    issue(64'h0000_0000_8000_0000, 6'd33, 3'd2, 1'b1, 5'd4, 64'hFFFF_FFFF_C000_0000);
    issue(64'h1, 6'd4, 3'd4, 1'b0, 5'd5, ROT ? 64'h1000_0000_0000_0000 : 64'h0);
    issue(64'h1, 6'd1, 3'd4, 1'b1, 5'd6, ROT ? 64'hFFFF_FFFF_8000_0000 : 64'h0);
    issue(64'h8000_0000_0000_0001, 6'd1, 3'd3, 1'b0, 5'd7, ROT ? 64'h3 : 64'h0);
    issue(64'h0123_4567_89AB_CDEF, 6'd0, 3'd0, 1'b0, 5'd8, 64'h0123_4567_89AB_CDEF);
    issue(64'h1234_5678_8765_4321, 6'd0, 3'd1, 1'b1, 5'd9, 64'hFFFF_FFFF_8765_4321);
    issue(64'hDEAD_BEEF_DEAD_BEEF, 6'd5, 3'd7, 1'b0, 5'd10, 64'h0);
    drain();

    // Back-to-back stream under 1,0,0 backpressure.
    rr_mode = 1; cyc = 0;
    for (int i = 0; i < 10; i++) issue_rand(5'(i + 11));
    drain();

    // Flush with both stages full and a request in the same cycle.
    begin
      bit a;
      rr_mode = 3;
      issue(64'hAAAA, 6'd1, 3'd0, 1'b0, 5'd21, 64'h0);
      issue(64'hBBBB, 6'd2, 3'd0, 1'b0, 5'd22, 64'h0);
      step(1'b1, 64'hCCCC, 6'd3, 3'd0, 1'b0, 5'd23, 64'h0, 1'b1, a);
      rr_mode = 0;
      repeat (4) idle();
      issue(64'h1, 6'd8, 3'd0, 1'b0, 5'd24, 64'h100);
      idle(); #2;
      chk("lat_edge1_valid", 64'(resp_valid), 64'h0);
      idle(); #2;
      chk("lat_edge2_valid", 64'(resp_valid), 64'h1);
      drain();
    end

    // Randomized traffic with random gaps and backpressure.
    rr_mode = 2;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else issue_rand(5'($urandom));
    end
    drain();

    // Asynchronous reset with both stages loaded.
    rr_mode = 3;
    issue(64'h55, 6'd1, 3'd0, 1'b0, 5'd1, 64'h0);
    issue(64'h66, 6'd1, 3'd0, 1'b0, 5'd2, 64'h0);
    @(posedge clk); #3;
    req_valid = 1'b0;
    chk("pre_rst_valid", 64'(resp_valid), 64'h1);
    rst_n = 1'b0; #1;
    chk("async_rst_valid", 64'(resp_valid), 64'h0);
    chk("async_rst_ready", 64'(req_ready), 64'h1);
    chk("async_rst_data", resp_data, 64'h0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    rr_mode = 2;
    for (int i = 0; i < 20; i++) issue_rand(5'(i));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
